// File: rtl/uart_pkg.sv
// Shared UART constants, frame builders and state enum for the register-write link (tx and rx).
// UART_TX_STOP2_EN: two stop bits per frame (11-bit frames) instead of one.
package uart_pkg;
    localparam int BAUD_DIV = 5;
    localparam int WIDTH    = 10;
`ifdef UART_TX_STOP2_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int NUM_STOP = FRAME_BITS - 9;

    localparam logic START = 1'b0;
    localparam logic STOP  = 1'b1;
    localparam logic [FRAME_BITS-1:0] IDLE_LINE = '1;

    typedef enum logic [1:0] {IDLE, BYTE1, BYTE2} state_t;

    // Frame 1 payload: D0..D6 then a 0 msb, so the receiver can tell it from frame 2.
    function automatic logic [FRAME_BITS-1:0] frame1(input logic [7:0] d);
        frame1 = {{NUM_STOP{STOP}}, 1'b0, d[6:0], START};
    endfunction

    // Frame 2 payload: D7, A0..A3, two zero pad bits, then the msb qualifier 1.
    function automatic logic [FRAME_BITS-1:0] frame2(input logic [3:0] a, input logic d7);
        frame2 = {{NUM_STOP{STOP}}, 1'b1, 2'b00, a, d7, START};
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period strobe: o_tick high for 1 clk every BAUD_DIV enabled clks; i_restart zeroes the phase.
// No backpressure; count holds while i_en is low.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);
    logic [2:0] r_cnt;
    logic       w_wrap;

    assign w_wrap = (r_cnt == 3'(BAUD_DIV - 1));
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? 3'd0 : r_cnt + 3'd1;
        end
    end
endmodule

// File: rtl/uart_tx.sv
// Two-frame UART register-write transmitter; start bit on the line 1 clk after accept, 2*FRAME_BITS*BAUD_DIV clks per message.
// tx_ready only in IDLE, so requests stall while a message is in flight. UART_TX_STOP2_EN selects two stop bits.
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tx_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);
    state_t                r_state;
    state_t                w_next;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bit_cnt;
    logic                  r_busy;
    logic [3:0]            r_addr;
    logic                  r_d7;
    logic                  w_accept;
    logic                  w_tick;
    logic                  w_frame_end;

    assign w_accept    = tx_valid && (r_state == IDLE);
    assign w_frame_end = w_tick && (r_bit_cnt == 4'd0);

    uart_baud_tick u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_accept),
        .i_en      (r_state != IDLE),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (tx_valid)    w_next = BYTE1;
            BYTE1:   if (w_frame_end) w_next = BYTE2;
            BYTE2:   if (w_frame_end) w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (r_state == IDLE);
        tx       = r_shift[0];
        tx_busy  = r_busy;
    end

    // Shifting fills with STOP, so the line is already idle-high once the last stop bit leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= IDLE_LINE;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_d7      <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= frame1(tx_data);
            r_bit_cnt <= 4'(FRAME_BITS - 1);
            r_busy    <= 1'b1;
            r_addr    <= tx_addr;
            r_d7      <= tx_data[7];
        end else if (w_tick) begin
            if (r_bit_cnt != 4'd0) begin
                r_shift   <= {STOP, r_shift[FRAME_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt - 4'd1;
            end else if (r_state == BYTE1) begin
                r_shift   <= frame2(r_addr, r_d7);
                r_bit_cnt <= 4'(FRAME_BITS - 1);
            end else begin
                r_shift   <= IDLE_LINE;
                r_busy    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted requests queue an expected message; a line monitor
// checks every clk of the serial waveform against a behavioural two-character UART model.
module tb_uart_tx;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int BITCLK = 5;
    localparam int FB     = 9 + NSTOP;
    localparam int MSG    = 2 * FB * BITCLK;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_addr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .tx_addr  (tx_addr),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } req_t;

    req_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // The message is two ordinary UART characters: char0 = data mod 128,
    // char1 = data div 128 + 2*addr + 128; each is start, 8 bits lsb first, NSTOP stops.
    function automatic logic line_bit(input req_t r, input int i);
        int ch, p, b;
        ch = i / FB;
        p  = i % FB;
        b  = (ch == 0) ? (int'(r.d) % 128) : (int'(r.d) / 128 + int'(r.a) * 2 + 128);
        if (p == 0) return 1'b0;
        if (p <= 8) return 1'((b >> (p - 1)) & 1);
        return 1'b1;
    endfunction

    // Monitor/scoreboard: sole owner of the queue.
    bit               active   = 0;
    bit               idle_chk = 0;
    int               k        = 0;
    int               werr     = 0;
    req_t             cur;
    logic [2*FB-1:0]  smp;
    logic [7:0]       last_b1, last_b2;

    always @(negedge clk) begin
        if (rst) begin
            active   = 0;
            idle_chk = 0;
            q.delete();
        end else begin
            if (idle_chk) begin
                idle_chk = 0;
                check("idle_after_msg", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
            end
            if (tx_valid && tx_ready) begin
                q.push_back('{a: tx_addr, d: tx_data});
                n_acc++;
            end
            if (!active && tx == 1'b0) begin
                check("start_has_request", q.size() > 1 || (q.size() == 1 && !(tx_valid && tx_ready)), 1);
                if (q.size() > 0) begin
                    cur    = q[0];
                    active = 1;
                    k      = 0;
                    werr   = 0;
                end
            end
            if (active) begin
                if (tx !== line_bit(cur, k / BITCLK)) werr++;
                if (tx_ready !== 1'b0 || tx_busy !== 1'b1) werr++;
                if (k % BITCLK == 2) smp[k / BITCLK] = tx;
                k++;
                if (k == MSG) begin
                    active = 0;
                    void'(q.pop_front());
                    last_b1 = smp[8:1];
                    last_b2 = smp[FB+8 -: 8];
                    check("waveform", werr, 0);
                    check("rx_addr", {28'd0, last_b2[4:1]}, {28'd0, cur.a});
                    check("rx_data", {24'd0, last_b2[0], last_b1[6:0]}, {24'd0, cur.d});
                    idle_chk = 1;
                end
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [7:0] d);
        int n;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_addr  = a;
        tx_data  = d;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        if (n == 400) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lows);
        int n;
        lows = 0;
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (tx_ready) break;
            lows++;
        end
        if (n == 1000) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows, acc0, bad_idle;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_addr  = '0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
        @(posedge clk);
        #1 rst = 1'b0;

        bad_idle = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad_idle++;
        end
        check("idle_200", bad_idle, 0);

        send(4'h5, 8'hA3);
        wait_idle(lows);
        check("ready_low_clks", lows, MSG);
        @(negedge clk);
        check("byte1", {24'd0, last_b1}, 32'h23);
        check("byte2", {24'd0, last_b2}, 32'h8B);

        send(4'hF, 8'h80);
        send(4'h0, 8'h7F);
        wait_idle(lows);

        // valid held high: one message per MSG+1 clks at most
        acc0 = n_acc;
        @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_addr  = 4'h9;
        tx_data  = 8'h3C;
        repeat (3 * (MSG + 1)) @(posedge clk);
        #1 tx_valid = 1'b0;
        check("held_valid_accepts", n_acc - acc0, 3);
        wait_idle(lows);

        // reset in the 37th clk of a message
        send(4'hC, 8'hE1);
        repeat (36) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_reset_line", {30'd0, tx, tx_ready}, 32'b11);
        send(4'h3, 8'h55);
        wait_idle(lows);

        // reset and valid together: reset wins
        acc0 = n_acc;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_valid = 1'b0;
        bad_idle = 0;
        repeat (2 * MSG) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1) bad_idle++;
        end
        check("rst_beats_valid", bad_idle, 0);
        check("rst_beats_valid_acc", n_acc - acc0, 0);

        // random messages with valid noise while busy
        for (int m = 0; m < 15; m++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send(4'($urandom), 8'($urandom));
            for (int c = 0; c < MSG - 20; c++) begin
                @(posedge clk);
                #1;
                tx_valid = 1'($urandom);
                tx_addr  = 4'($urandom);
                tx_data  = 8'($urandom);
            end
            @(posedge clk);
            #1 tx_valid = 1'b0;
            wait_idle(lows);
        end

        repeat (MSG + 10) @(negedge clk);
        check("queue_drained", {31'd0, active} + q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
